// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> memory/datapath signal bundle
interface mips_multicycle_ctrl_if;

  logic [31:0] instruction;
  logic        mem_ready;
  logic        alu_zero;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic        signal_ir_write;
  logic        signal_pc_write;
  logic [1:0]  signal_pc_src;
  logic        signal_alu_src;
  logic [2:0]  alu_op;
  logic        signal_reg_write;
  logic [2:0]  write_reg;
  logic        signal_mem_to_reg;
  logic        signal_illegal;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  instruction, mem_ready, alu_zero,
    output signal_mem_read, signal_mem_write, signal_ir_write, signal_pc_write,
           signal_pc_src, signal_alu_src, alu_op, signal_reg_write, write_reg,
           signal_mem_to_reg, signal_illegal, state, instr_count
  );

  modport slave (
    output instruction, mem_ready, alu_zero,
    input  signal_mem_read, signal_mem_write, signal_ir_write, signal_pc_write,
           signal_pc_src, signal_alu_src, alu_op, signal_reg_write, write_reg,
           signal_mem_to_reg, signal_illegal, state, instr_count
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational opcode classifier
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output instr_class_t cls,
  output logic         dest_rd,
  output logic [2:0]   alu_op,
  output logic         alu_src,
  output logic         legal
);

  always_comb begin
    cls     = CLS_ILLEGAL;
    dest_rd = 1'b0;
    alu_op  = ALU_ADD;
    alu_src = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        cls     = CLS_RTYPE;
        dest_rd = 1'b1;
        alu_op  = ALU_FUNCT;
        alu_src = 1'b0;
      end
      OP_J:           cls = CLS_JUMP;
      OP_BEQ, OP_BNE: begin
        cls     = CLS_BRANCH;
        alu_op  = ALU_SUB;
        alu_src = 1'b0;
      end
      OP_ADDI:        cls = CLS_IMM;
      OP_SLTI: begin
        cls    = CLS_IMM;
        alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        cls    = CLS_IMM;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        cls    = CLS_IMM;
        alu_op = ALU_OR;
      end
      OP_LW:          cls = CLS_LOAD;
      OP_SW:          cls = CLS_STORE;
      default:        cls = CLS_ILLEGAL;
    endcase
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with IR and retired-instruction counter
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);

  state_t       state_q, state_d;
  logic [31:0]  ir_q;
  logic [31:0]  count_q;
  logic         count_inc;

  instr_class_t cls;
  logic         dest_rd, alu_src_dec, legal_op;
  logic [2:0]   alu_op_dec, dest;

  logic         mem_read, mem_write, ir_write, pc_write, alu_src;
  logic         reg_write, mem_to_reg, illegal;
  logic [1:0]   pc_src;
  logic [2:0]   alu_op, write_reg;

  logic         unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[25:19], ir_q[15:14], ir_q[10:0]};

  mips_ctrl_decode u_decode (
    .opcode  (ir_q[31:26]),
    .cls     (cls),
    .dest_rd (dest_rd),
    .alu_op  (alu_op_dec),
    .alu_src (alu_src_dec),
    .legal   (legal_op)
  );

  assign dest = dest_rd ? ir_q[13:11] : ir_q[18:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write)  ir_q    <= bus.instruction;
      if (count_inc) count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_inc  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    write_reg  = 3'd0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_JUMP) begin
          pc_write  = 1'b1;
          pc_src    = PC_SRC_JUMP;
          count_inc = 1'b1;
          state_d   = ST_FETCH;
        end else if (!legal_op) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        case (cls)
          CLS_BRANCH: begin
            // beq takes on zero, bne takes on non-zero
            if (bus.alu_zero == (ir_q[31:26] == OP_BEQ)) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BRANCH;
            end
            count_inc = 1'b1;
            state_d   = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_op    = alu_op_dec;
        mem_read  = (cls == CLS_LOAD);
        mem_write = (cls == CLS_STORE);
        if (bus.mem_ready) begin
          if (cls == CLS_STORE) begin
            count_inc = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        // alu_op stays valid so the ALU result feeding the write port is stable
        alu_op     = alu_op_dec;
        write_reg  = dest;
        reg_write  = (dest != 3'd0);
        mem_to_reg = (cls == CLS_LOAD);
        count_inc  = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign bus.signal_mem_read   = mem_read   & ~reset;
  assign bus.signal_mem_write  = mem_write  & ~reset;
  assign bus.signal_ir_write   = ir_write   & ~reset;
  assign bus.signal_pc_write   = pc_write   & ~reset;
  assign bus.signal_pc_src     = reset ? 2'd0 : pc_src;
  assign bus.signal_alu_src    = alu_src    & ~reset;
  assign bus.alu_op            = reset ? 3'd0 : alu_op;
  assign bus.signal_reg_write  = reg_write  & ~reset;
  assign bus.write_reg         = reset ? 3'd0 : write_reg;
  assign bus.signal_mem_to_reg = mem_to_reg & ~reset;
  assign bus.signal_illegal    = illegal    & ~reset;
  assign bus.state             = reset ? 3'd0 : state_q;
  assign bus.instr_count       = reset ? 32'd0 : count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, irw, pcw;
    logic [1:0] pcs;
    logic       asrc;
    logic [2:0] aop;
    logic       rw;
    logic [2:0] wr;
    logic       m2r, ill;
  } obs_t;

  typedef struct packed {
    logic rdy;
    logic zero;
    obs_t o;
  } ent_t;

  logic        clk;
  logic        reset;
  ent_t        tr[$];
  logic [31:0] exp_count;
  int          vectors;
  int          miscompares;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.st   = bus.state;
    o.mr   = bus.signal_mem_read;
    o.mw   = bus.signal_mem_write;
    o.irw  = bus.signal_ir_write;
    o.pcw  = bus.signal_pc_write;
    o.pcs  = bus.signal_pc_src;
    o.asrc = bus.signal_alu_src;
    o.aop  = bus.alu_op;
    o.rw   = bus.signal_reg_write;
    o.wr   = bus.write_reg;
    o.m2r  = bus.signal_mem_to_reg;
    o.ill  = bus.signal_illegal;
    return o;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(input logic rdy, input logic zero, input obs_t o);
    ent_t e;
    e.rdy  = rdy;
    e.zero = zero;
    e.o    = o;
    tr.push_back(e);
  endfunction

  // Per-cycle expectation of one instruction, derived from its opcode class
  function automatic void build(input logic [31:0] ins, input logic zero, input int fw, input int mw);
    logic [5:0] op     = ins[31:26];
    bit         is_r   = (op == 6'h00);
    bit         is_j   = (op == 6'h02);
    bit         is_br  = (op == 6'h04) || (op == 6'h05);
    bit         is_lw  = (op == 6'h23);
    bit         is_sw  = (op == 6'h2B);
    bit         is_imm = (op == 6'h08) || (op == 6'h0A) || (op == 6'h0C) || (op == 6'h0D);
    bit         legal  = is_r || is_j || is_br || is_lw || is_sw || is_imm;
    logic [2:0] aop;
    logic [2:0] dest   = is_r ? ins[13:11] : ins[18:16];
    obs_t       o;
    if (is_r)              aop = 3'd7;
    else if (is_br)        aop = 3'd1;
    else if (op == 6'h0C)  aop = 3'd2;
    else if (op == 6'h0D)  aop = 3'd3;
    else if (op == 6'h0A)  aop = 3'd4;
    else                   aop = 3'd0;
    tr.delete();
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mr = 1'b1;
      add(1'b0, rnd_bit(), o);
    end
    o = '0; o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
    add(1'b1, rnd_bit(), o);
    o = '0; o.st = 3'd1;
    if (is_j) begin o.pcw = 1'b1; o.pcs = 2'd2; end
    if (!legal) o.ill = 1'b1;
    add(rnd_bit(), rnd_bit(), o);
    if (is_j) begin exp_count = exp_count + 32'd1; return; end
    if (!legal) return;
    o = '0; o.st = 3'd2; o.asrc = !(is_r || is_br); o.aop = aop;
    if (is_br && (zero == (op == 6'h04))) begin o.pcw = 1'b1; o.pcs = 2'd1; end
    add(rnd_bit(), is_br ? zero : rnd_bit(), o);
    if (is_br) begin exp_count = exp_count + 32'd1; return; end
    if (is_lw || is_sw) begin
      o = '0; o.st = 3'd3; o.mr = is_lw; o.mw = is_sw; o.aop = aop;
      for (int i = 0; i < mw; i++) add(1'b0, rnd_bit(), o);
      add(1'b1, rnd_bit(), o);
      if (is_sw) begin exp_count = exp_count + 32'd1; return; end
    end
    o = '0; o.st = 3'd4; o.aop = aop; o.wr = dest; o.rw = (dest != 3'd0); o.m2r = is_lw;
    add(rnd_bit(), rnd_bit(), o);
    exp_count = exp_count + 32'd1;
  endfunction

  task automatic drive(input logic rdy, input logic zero);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.alu_zero  = zero;
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.alu_zero = 1'b1; bus.instruction = $urandom();
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (sample() !== '0 || bus.instr_count !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h count %h, want 0", i, sample(), bus.instr_count);
      end
      @(negedge clk); #1;
    end
    reset = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    o = '0; o.mr = 1'b1;
    exp_count = 32'd0;
    vectors++;
    if (sample() !== o || bus.instr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %h count %h, want %h count 0", sample(), bus.instr_count, o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins [7] = '{32'h00221820, 32'h8C220004, 32'h10220003, 32'h10220003,
                             32'hFC000000, 32'hAC220004, 32'h08000010};
    logic        zr  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          mwt [7] = '{0, 3, 0, 0, 0, 2, 0};
    for (int k = 0; k < 7; k++) begin
      build(ins[k], zr[k], k % 2, mwt[k]);
      bus.instruction = ins[k];
      foreach (tr[i]) begin
        drive(tr[i].rdy, tr[i].zero);
        vectors++;
        if (sample() !== tr[i].o) begin
          miscompares++;
          $display("FAIL directed ins=%h cycle %0d: got %h want %h", ins[k], i, sample(), tr[i].o);
        end
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.instr_count !== exp_count) begin
        miscompares++;
        $display("FAIL directed_count ins=%h: got %0d want %0d", ins[k], bus.instr_count, exp_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    logic [31:0] r, ins;
    logic [5:0]  op;
    logic        zero;
    for (int k = 0; k < 150; k++) begin
      r    = $urandom();
      op   = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 9)];
      ins  = {op, r[25:0]};
      zero = rnd_bit();
      build(ins, zero, $urandom_range(0, 2), $urandom_range(0, 3));
      bus.instruction = ins;
      foreach (tr[i]) begin
        drive(tr[i].rdy, tr[i].zero);
        vectors++;
        if (sample() !== tr[i].o) begin
          miscompares++;
          $display("FAIL random ins=%h cycle %0d: got %h want %h", ins, i, sample(), tr[i].o);
        end
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.instr_count !== exp_count) begin
        miscompares++;
        $display("FAIL random_count ins=%h: got %0d want %0d", ins, bus.instr_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    build(32'hAC220004, 1'b0, 0, 2);
    bus.instruction = 32'hAC220004;
    for (int i = 0; i < 4; i++) begin
      drive(tr[i].rdy, tr[i].zero);
      vectors++;
      if (sample() !== tr[i].o) begin
        miscompares++;
        $display("FAIL mid_mem_lead cycle %0d: got %h want %h", i, sample(), tr[i].o);
      end
    end
    @(negedge clk);
    reset = 1'b1; bus.mem_ready = 1'b1;
    #1;
    vectors++;
    if (sample() !== '0 || bus.instr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_mem_reset: got %h count %h, want 0", sample(), bus.instr_count);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    exp_count = 32'd0;
    o = '0; o.mr = 1'b1;
    vectors++;
    if (sample() !== o || bus.instr_count !== exp_count) begin
      miscompares++;
      $display("FAIL mid_mem_after: got %h count %h, want %h count 0", sample(), bus.instr_count, o);
    end
  endtask

  task automatic test_wrap();
    bus.mem_ready = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    vectors++;
    if (bus.instr_count !== exp_count) begin
      miscompares++;
      $display("FAIL wrap_preset: got %h want %h", bus.instr_count, exp_count);
    end
    build(32'h20000005, 1'b0, 0, 0);
    bus.instruction = 32'h20000005;
    foreach (tr[i]) begin
      drive(tr[i].rdy, tr[i].zero);
      vectors++;
      if (sample() !== tr[i].o) begin
        miscompares++;
        $display("FAIL wrap_addi cycle %0d: got %h want %h", i, sample(), tr[i].o);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.instr_count !== 32'd0 || exp_count !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_count: got %h want 0", bus.instr_count);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    exp_count       = 32'd0;
    reset           = 1'b1;
    bus.mem_ready   = 1'b0;
    bus.alu_zero    = 1'b0;
    bus.instruction = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_mem();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: instruction  in  32  instruction-memory read data, valid when mem_ready=1 in FETCH.
REQ-004 SHALL have: mem_ready  in  1  memory handshake, request accepted/data valid this cycle.
REQ-005 SHALL have: alu_zero  in  1  ALU zero flag, valid in EXEC.
REQ-006 SHALL have outputs: signal_mem_read, signal_mem_write, signal_ir_write, signal_pc_write  1 each  memory/IR/PC strobes.
REQ-007 SHALL have: signal_pc_src  out  2  00=PC+4, 01=branch target, 10=jump target.
REQ-008 SHALL have: signal_alu_src  out  1  (0=register, 1=sign-extended immediate); alu_op  out  3.
REQ-009 SHALL have: signal_reg_write  out  1; write_reg  out  3; signal_mem_to_reg  out  1.  These drive the register file write port.
REQ-010 SHALL have: signal_illegal  out  1; state  out  3; instr_count  out  32  retired-instruction count.

Function
REQ-011 Field decoding SHALL be: opcode=instr[31:26], rt=instr[18:16], rd=instr[13:11], funct=instr[5:0].
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-013 In FETCH, the block SHALL assert signal_mem_read and wait while mem_ready=0.
REQ-014 On mem_ready=1 in FETCH, in that same cycle it SHALL assert signal_ir_write, signal_pc_write and pc_src=00, latch the instruction into an internal IR, and go to DECODE.
REQ-015 DECODE on j (0x02) SHALL assert signal_pc_write, pc_src=10, and go to FETCH.
REQ-016 DECODE on an unsupported opcode SHALL pulse signal_illegal for 1 cycle and go to FETCH, with no write.
REQ-017 All other opcodes SHALL go from DECODE to EXEC.
REQ-018 In EXEC, alu_op SHALL be: R-type (0x00)=111 (ALU uses funct); addi 0x08, lw 0x23, sw 0x2B=000 ADD; beq 0x04, bne 0x05=001 SUB; andi 0x0C=010; ori 0x0D=011; slti 0x0A=100.
REQ-019 In EXEC, signal_alu_src SHALL be 0 for R-type, beq and bne, and 1 otherwise.
REQ-020 For beq/bne, EXEC SHALL assert signal_pc_write with pc_src=01 only if alu_zero==1 (beq) or alu_zero==0 (bne), then go to FETCH.
REQ-021 From EXEC, lw and sw SHALL go to MEM; R-type and immediate ops SHALL go to WB.
REQ-022 In MEM, lw SHALL assert signal_mem_read and sw signal_mem_write, holding while mem_ready=0.
REQ-023 On mem_ready=1 in MEM, lw SHALL go to WB and sw to FETCH.
REQ-024 In WB, signal_reg_write SHALL be high for exactly 1 cycle, then the FSM goes to FETCH.
REQ-025 In WB, write_reg SHALL be rd for R-type and rt otherwise; signal_mem_to_reg=1 only for lw.
REQ-026 In WB, signal_reg_write SHALL be suppressed when write_reg==0.
REQ-027 instr_count SHALL increment by 1 on the final cycle of every legal instruction: WB exit, sw MEM exit, branch EXEC exit, j DECODE exit.
REQ-028 instr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 Strobes SHALL be Moore decodes of state+IR, except handshake-qualified strobes (ir_write, pc_write in FETCH), which SHALL be gated combinationally by mem_ready.
REQ-030 Strobes and write_reg SHALL be 0 in states where they are not named above.
REQ-031 Latencies (mem_ready=1 throughout) SHALL be: R/imm 4, lw 5, sw 4, branch 3, j 2 cycles.

Reset
REQ-032 While reset=1, all outputs SHALL be 0, with state forced to FETCH at the next edge.
REQ-033 Reset SHALL clear IR and instr_count to 0.
REQ-034 Reset in any state, including mid-MEM handshake, SHALL abort the instruction with no reg/mem write and no count increment.

Structure
REQ-035 A shared package mips_ctrl_pkg SHALL hold the state encodings, opcode constants, alu_op codes and pc_src codes.
REQ-036 Opcode classification SHALL be a combinational sub-module mips_ctrl_decode (opcode -> class, dest select, alu_op, legal).
REQ-037 The FSM, IR and counter SHALL be in the top module.

Verification
REQ-038 add $3,$1,$2 (0x00221820), mem_ready=1 -> reg_write=1, write_reg=3, alu_op=111 in cycle 4; instr_count=1.
REQ-039 lw $2,4($1) (0x8C220004) with mem_ready low 3 cycles in MEM -> MEM held 4 cycles; WB write_reg=2, mem_to_reg=1.
REQ-040 beq (0x10220003): alu_zero=1 -> pc_write, pc_src=01 in EXEC; alu_zero=0 -> no pc_write; FETCH follows in both cases.
REQ-041 Opcode 0x3F (0xFC000000) -> signal_illegal pulses 1 cycle in DECODE; no reg_write; instr_count unchanged.
REQ-042 sw (0xAC220004) with reset asserted during MEM -> mem_write drops, state=FETCH, instr_count=0.
REQ-043 addi $0,$0,5 (0x20000005) -> WB reached, signal_reg_write stays 0; instr_count at 0xFFFFFFFF preset wraps to 0.
